// File: rtl/hif_fir_engine.sv
// rtl/hif_fir_engine.sv - NUM_TAPS-tap MAC FIR stage fed by the high-frequency sample queue.
// Optional macro HIF_FIR_ROUND_EN: round half up before the Q15 scale instead of truncating.
module hif_fir_engine #(
  parameter int NUM_TAPS = 1021,
  parameter int COEFF_W  = 16,
  parameter int ACC_W    = 42,
  parameter int TAP_AW   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrt_smpl,
  input  logic                      sequencing,
  input  logic signed [15:0]        smpl_in,
  output logic                      rd_en,
  output logic [TAP_AW-1:0]         coeff_addr,
  input  logic signed [COEFF_W-1:0] coeff_in,
  output logic signed [15:0]        filt_out,
  output logic                      filt_vld,
  output logic                      busy,
  output logic                      overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SCALE} state_t;

  localparam int PROD_W = 16 + COEFF_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = 32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -32768;
  localparam logic [TAP_AW-1:0]       LAST_TAP = TAP_AW'(NUM_TAPS - 1);

  state_t                    state, state_nxt;
  logic [TAP_AW-1:0]         tap;
  logic                      mac_en;
  logic signed [ACC_W-1:0]   acc;
  logic signed [PROD_W-1:0]  prod_full;
  logic signed [ACC_W-1:0]   prod, sum, biased, shifted;
  logic signed [15:0]        sat;
  logic                      start, last_tap;

  assign start    = wrt_smpl && sequencing;
  assign last_tap = (tap == LAST_TAP);

  // Sample and coefficient return one cycle after the request, so mac_en trails FETCH.
  assign prod_full = smpl_in * coeff_in;
  assign prod      = {{(ACC_W-PROD_W){prod_full[PROD_W-1]}}, prod_full};
  assign sum       = mac_en ? acc + prod : acc;

`ifdef HIF_FIR_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF_LSB = 16384;
  assign biased = sum + HALF_LSB;
`else
  assign biased = sum;
`endif
  assign shifted = biased >>> 15;

  always_comb begin
    sat = shifted[15:0];
    if (shifted > SAT_MAX) sat = 16'sh7fff;
    else if (shifted < SAT_MIN) sat = -16'sh8000;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (last_tap) state_nxt = DRAIN;
      DRAIN:   state_nxt = SCALE;
      SCALE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en      = (state == FETCH);
  assign busy       = (state != IDLE);
  assign filt_vld   = (state == SCALE);
  assign coeff_addr = tap;

  // filt_out is registered as DRAIN folds in the last product, so it is valid during SCALE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tap      <= '0;
      mac_en   <= 1'b0;
      acc      <= '0;
      filt_out <= '0;
      overrun  <= 1'b0;
    end else begin
      state  <= state_nxt;
      mac_en <= (state == FETCH);
      if (wrt_smpl && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          tap <= '0;
        end
        FETCH: begin
          acc <= sum;
          tap <= last_tap ? '0 : tap + TAP_AW'(1);
        end
        DRAIN: begin
          acc      <= sum;
          filt_out <= sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hif_fir_engine.sv
// tb/tb_hif_fir_engine.sv - directed checks of hif_fir_engine at 4 taps and full size.
module tb_hif_fir_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sequencing;

  // 4-tap instance
  logic               s_wrt, s_rd, s_vld, s_busy, s_ovr;
  logic [2:0]         s_addr;
  logic signed [15:0] s_smpl, s_coeff, s_filt;
  // full-size instance
  logic               f_wrt, f_rd, f_vld, f_busy, f_ovr;
  logic [9:0]         f_addr;
  logic signed [15:0] f_smpl, f_coeff, f_filt;

  hif_fir_engine #(.NUM_TAPS(4), .COEFF_W(16), .ACC_W(42), .TAP_AW(3)) u_small (
    .clk(clk), .rst(rst), .wrt_smpl(s_wrt), .sequencing(sequencing), .smpl_in(s_smpl),
    .rd_en(s_rd), .coeff_addr(s_addr), .coeff_in(s_coeff), .filt_out(s_filt),
    .filt_vld(s_vld), .busy(s_busy), .overrun(s_ovr));

  hif_fir_engine #(.NUM_TAPS(1021), .COEFF_W(16), .ACC_W(42), .TAP_AW(10)) u_full (
    .clk(clk), .rst(rst), .wrt_smpl(f_wrt), .sequencing(sequencing), .smpl_in(f_smpl),
    .rd_en(f_rd), .coeff_addr(f_addr), .coeff_in(f_coeff), .filt_out(f_filt),
    .filt_vld(f_vld), .busy(f_busy), .overrun(f_ovr));

  // queue and ROM models: one-cycle read latency
  logic [15:0] s_q [0:7];
  logic [15:0] s_rom [0:7];
  logic [2:0]  s_rptr;
  logic        q_clr;

  always @(posedge clk) begin
    s_coeff <= s_rom[s_addr];
    if (q_clr) s_rptr <= 3'd0;
    else if (s_rd) begin
      s_smpl <= s_q[s_rptr];
      s_rptr <= s_rptr + 3'd1;
    end
    f_coeff <= {8'd0, f_addr[7:0]};
    f_smpl  <= f_rd ? 16'sd64 : 16'sd0;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int r_nrd, r_first, r_last, r_nvld, r_vld_cyc, r_nbusy;
  logic [15:0] r_out, r_ro;
  logic r_rb, r_rr, r_rov;

  task automatic load(input logic [15:0] q0, q1, q2, q3, c0, c1, c2, c3);
    s_q[0] = q0; s_q[1] = q1; s_q[2] = q2; s_q[3] = q3;
    s_rom[0] = c0; s_rom[1] = c1; s_rom[2] = c2; s_rom[3] = c3;
  endtask

  task automatic run_small(input int wrt2_at, input int rst_at);
    q_clr = 1'b1;
    @(posedge clk); #1;
    q_clr = 1'b0;
    r_nrd = 0; r_first = -1; r_last = -1; r_nvld = 0; r_vld_cyc = -1; r_nbusy = 0;
    r_out = 16'hdead;
    s_wrt = 1'b1;
    @(posedge clk); #1;
    s_wrt = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (rst_at > 0 && c == rst_at + 1) begin
        rst = 1'b0;
        r_rb = s_busy; r_rr = s_rd; r_ro = s_filt; r_rov = s_ovr;
      end
      if (s_rd) begin
        r_nrd++;
        if (r_first < 0) r_first = c;
        r_last = c;
      end
      if (s_busy) r_nbusy++;
      if (s_vld) begin
        r_nvld++;
        r_vld_cyc = c;
        r_out = s_filt;
      end
      s_wrt = (c == wrt2_at);
      if (c == rst_at) rst = 1'b1;
      @(posedge clk); #1;
    end
    s_wrt = 1'b0;
  endtask

`ifdef HIF_FIR_ROUND_EN
  localparam logic [15:0] E_IMP = 16'h4000;
  localparam logic [15:0] E_MIX = 16'd125;
  localparam logic [15:0] E_NEG1 = 16'h0000;
  localparam logic [15:0] E_FULL = 16'd254;
`else
  localparam logic [15:0] E_IMP = 16'h3fff;
  localparam logic [15:0] E_MIX = 16'd124;
  localparam logic [15:0] E_NEG1 = 16'hffff;
  localparam logic [15:0] E_FULL = 16'd253;
`endif

  int f_nbusy, f_first, f_last, f_vld_cyc, f_nvld, f_maxaddr;
  logic [15:0] f_out;

  initial begin
    rst = 1'b1; sequencing = 1'b0; s_wrt = 1'b0; f_wrt = 1'b0; q_clr = 1'b1;
    for (int i = 0; i < 8; i++) begin s_q[i] = 16'h0; s_rom[i] = 16'h0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; q_clr = 1'b0;

    chk("rst_filt_out", s_filt, 16'h0);
    chk("rst_filt_vld", s_vld, 1'b0);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_overrun", s_ovr, 1'b0);
    chk("rst_rd_en", s_rd, 1'b0);
    chk("rst_coeff_addr", s_addr, 3'd0);

    // gated start
    load(16'h7fff, 0, 0, 0, 16'h4000, 16'h2000, 16'h1000, 16'h0800);
    run_small(0, 0);
    chk("gate_rd_cnt", r_nrd, 0);
    chk("gate_vld_cnt", r_nvld, 0);
    chk("gate_busy_cnt", r_nbusy, 0);

    sequencing = 1'b1;
    run_small(0, 0);
    chk("imp_rd_first", r_first, 1);
    chk("imp_rd_last", r_last, 4);
    chk("imp_rd_cnt", r_nrd, 4);
    chk("imp_vld_cyc", r_vld_cyc, 6);
    chk("imp_vld_cnt", r_nvld, 1);
    chk("imp_busy_cnt", r_nbusy, 6);
    chk("imp_out", r_out, E_IMP);
    chk("imp_hold", s_filt, E_IMP);
    chk("imp_no_ovr", s_ovr, 1'b0);

    load(16'd1000, -16'sd2000, 16'd3000, -16'sd4001, 16'h4000, 16'h2000, 16'h1000, 16'h0800);
    run_small(0, 0);
    chk("mix_out", r_out, E_MIX);

    load(16'hffff, 0, 0, 0, 16'h4000, 16'h2000, 16'h1000, 16'h0800);
    run_small(0, 0);
    chk("neg1_out", r_out, E_NEG1);

    load(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    run_small(0, 0);
    chk("psat_out", r_out, 16'h7fff);
    chk("psat_vld_cnt", r_nvld, 1);

    load(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    run_small(0, 0);
    chk("nsat_out", r_out, 16'h8000);

    // second strobe while busy
    load(16'h7fff, 0, 0, 0, 16'h4000, 16'h2000, 16'h1000, 16'h0800);
    run_small(2, 0);
    chk("ovr_flag", s_ovr, 1'b1);
    chk("ovr_vld_cnt", r_nvld, 1);
    chk("ovr_vld_cyc", r_vld_cyc, 6);
    chk("ovr_out", r_out, E_IMP);
    chk("ovr_rd_cnt", r_nrd, 4);
    run_small(0, 0);
    chk("ovr_sticky", s_ovr, 1'b1);

    // reset mid-convolution
    run_small(0, 3);
    chk("mrst_busy", r_rb, 1'b0);
    chk("mrst_rd_en", r_rr, 1'b0);
    chk("mrst_filt_out", r_ro, 16'h0);
    chk("mrst_overrun", r_rov, 1'b0);
    chk("mrst_vld_cnt", r_nvld, 0);
    run_small(0, 0);
    chk("post_rst_vld_cyc", r_vld_cyc, 6);
    chk("post_rst_out", r_out, E_IMP);

    // strobe coinciding with SCALE is refused but flags overrun
    run_small(6, 0);
    chk("scale_strobe_ovr", s_ovr, 1'b1);
    chk("scale_strobe_vld_cnt", r_nvld, 1);
    chk("scale_strobe_rd_cnt", r_nrd, 4);

    // full size: sample 64, coeff k mod 256
    f_nbusy = 0; f_first = -1; f_last = -1; f_vld_cyc = -1; f_nvld = 0; f_maxaddr = 0;
    f_out = 16'hdead;
    f_wrt = 1'b1;
    @(posedge clk); #1;
    f_wrt = 1'b0;
    for (int c = 1; c <= 1030; c++) begin
      if (f_busy) begin
        f_nbusy++;
        if (f_first < 0) f_first = c;
        f_last = c;
      end
      if (f_vld) begin
        f_nvld++;
        f_vld_cyc = c;
        f_out = f_filt;
      end
      if (int'(f_addr) > f_maxaddr) f_maxaddr = int'(f_addr);
      @(posedge clk); #1;
    end
    chk("full_busy_first", f_first, 1);
    chk("full_busy_last", f_last, 1023);
    chk("full_busy_cnt", f_nbusy, 1023);
    chk("full_vld_cyc", f_vld_cyc, 1023);
    chk("full_vld_cnt", f_nvld, 1);
    chk("full_out", f_out, E_FULL);
    chk("full_max_addr", f_maxaddr, 1020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hif_fir_engine.md
Name: hif_fir_engine

Overview:
- Multiply-accumulate FIR stage directly downstream of the high-frequency 1536x16 circular sample queue.
- On each new audio sample strobe, once the queue reports it is sequencing, fetches NUM_TAPS consecutive samples from the queue read port and NUM_TAPS coefficients from an external coefficient ROM.
- Accumulates the products, then scales and saturates the sum to one 16-bit filtered sample with a one-cycle valid pulse.
- The output feeds the band-summing/volume stage.

Parameters:
- NUM_TAPS, 1021: filter length; number of sample/coefficient pairs per output.
- COEFF_W, 16: signed coefficient width, Q1.15.
- ACC_W, 42: signed accumulator width (32-bit product + 10 bits headroom).
- TAP_AW, 10: width of coeff_addr; must satisfy 2^TAP_AW >= NUM_TAPS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wrt_smpl  in  1  one-cycle new-sample strobe (same strobe that writes the queue).
- sequencing  in  1  queue primed; high once the queue has filled for the first time.
- smpl_in  in  16  signed sample from queue read port; valid 1 cycle after rd_en.
- rd_en  out  1  advance queue read pointer / request next sample.
- coeff_addr  out  TAP_AW  coefficient ROM address.
- coeff_in  in  COEFF_W  signed coefficient; valid 1 cycle after coeff_addr is presented.
- filt_out  out  16  signed filtered sample, held until the next update.
- filt_vld  out  1  one-cycle pulse when filt_out updates.
- busy  out  1  high while a convolution is in progress.
- overrun  out  1  sticky; a start strobe arrived while busy.

Behaviour:
- Reset (rst sampled high on a clk edge): state=IDLE; filt_out=0, filt_vld=0, busy=0, overrun=0, rd_en=0, coeff_addr=0, accumulator=0, tap counter=0. Reset overrides everything, including mid-convolution; the aborted convolution produces no filt_vld.
- States: IDLE, FETCH, DRAIN, SCALE.
- IDLE: if wrt_smpl && sequencing, clear accumulator, go to FETCH. If wrt_smpl && !sequencing, ignore.
- FETCH: rd_en=1, coeff_addr=k for k=0..NUM_TAPS-1, one per cycle. Each cycle, add the product of the previous pair (arriving with 1-cycle latency) to the accumulator. After k=NUM_TAPS-1 go to DRAIN.
- DRAIN: rd_en=0; accumulate the last product; go to SCALE.
- SCALE: compute s = acc >>> 15 (arithmetic). If s > 32767, filt_out=32767; if s < -32768, filt_out=-32768; else filt_out=s[15:0]. Pulse filt_vld, go to IDLE.
- Timing: cycle 0 is the cycle wrt_smpl is sampled in IDLE.
  - rd_en high in cycles 1..NUM_TAPS.
  - filt_out updates and filt_vld is high in cycle NUM_TAPS+2.
  - Throughput: one output per NUM_TAPS+3 cycles minimum.
- busy: high in FETCH, DRAIN and SCALE; low in IDLE.
- Product: full 32-bit signed product, sign-extended to ACC_W. No intermediate saturation; ACC_W guarantees no wrap for NUM_TAPS <= 1024.
- wrt_smpl while busy: ignored; overrun set and held until rst. The current convolution completes unaffected.
- wrt_smpl in the same cycle that SCALE returns to IDLE: not accepted (state is still SCALE); sets overrun.
- sequencing falling mid-convolution: the current convolution completes; subsequent starts are gated.
- Addressing: coeff_addr never exceeds NUM_TAPS-1. Queue-side wrap-around is owned by the queue; this block only issues rd_en.

Optional Feature:
- Macro: HIF_FIR_ROUND_EN.
- Defined: SCALE adds 2^14 to acc before the >>>15 shift (round half up), then saturates as above.
- Undefined: truncation only (floor via arithmetic shift).
- Latency is identical in both builds.

Test Plan:
- Impulse, NUM_TAPS=4, coeffs {0x4000,0x2000,0x1000,0x0800}, samples {0x7FFF,0,0,0}, sequencing=1, wrt_smpl pulse -> filt_vld in cycle 6; filt_out=0x3FFF truncated (0x4000 with HIF_FIR_ROUND_EN); rd_en high exactly cycles 1-4.
- Positive saturation, NUM_TAPS=4, all samples 0x7FFF, all coeffs 0x7FFF -> filt_out=0x7FFF (32767), filt_vld for one cycle.
- Negative saturation, all samples 0x8000, all coeffs 0x7FFF -> filt_out=0x8000 (-32768).
- Gating/overrun: wrt_smpl with sequencing=0 -> no rd_en, no filt_vld, busy=0. With sequencing=1, a second wrt_smpl in cycle 2 -> overrun=1 and stays 1; exactly one filt_vld, in cycle 6.
- Reset mid-operation: rst asserted in cycle 3 -> next cycle busy=0, rd_en=0, filt_out=0, overrun=0; no filt_vld. A new wrt_smpl then produces a correct result in cycle 6 relative to the new start.
- Full-size run, NUM_TAPS=1021, random samples/coeffs vs reference model -> bit-exact filt_out in cycle 1023; busy high for cycles 1-1023.
